// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog_if.sv
// Control/status bundle for the programmable clock divider.
// The master drives the run request and ratio; the slave (divider) returns the clocks and status.
interface gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog_if #(
  parameter int WIDTH = 4
);
  logic             EN;
  logic [WIDTH-1:0] DIV;
  logic             Z;
  logic             ZN;
  logic             TICK;
  logic             ACT;

  modport master (output EN, DIV, input Z, ZN, TICK, ACT);
  modport slave  (input EN, DIV, output Z, ZN, TICK, ACT);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog.sv
// Programmable glitch-free clock divider; ratio and enable only take effect at period starts.
// Optional GF180MCU_CLKDIV_DUTY50_EN adds a falling-edge flop giving 50% duty on odd ratios.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog #(
  parameter int WIDTH   = 4,
  parameter int MIN_DIV = 2
) (
`ifdef USE_POWER_PINS
  inout  wire  VDD,
  inout  wire  VSS,
`endif
  input  logic CLK,
  input  logic RST,
  gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic             z_q, z_d;
  logic             zn_q, zn_d;
  logic             tick_q, tick_d;
  logic             act_q, act_d;

  logic [WIDTH-1:0] n_eff, h, cnt_inc, n_m1;

  assign n_eff   = (bus.DIV < MIN_W) ? MIN_W : bus.DIV;
  assign h       = n_q >> 1;
  assign cnt_inc = cnt_q + ONE_W;
  assign n_m1    = n_q - ONE_W;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    z_d     = z_q;
    zn_d    = zn_q;
    tick_d  = 1'b0;
    act_d   = act_q;
    if (state_q == IDLE) begin
      if (bus.EN) begin
        state_d = RUN;
        cnt_d   = '0;
        n_d     = n_eff;
        z_d     = 1'b1;
        zn_d    = 1'b0;
        tick_d  = 1'b1;
        act_d   = 1'b1;
      end
    end else if (cnt_q == n_m1) begin
      // Period end is the only point where EN and DIV are honoured.
      cnt_d = '0;
      if (bus.EN) begin
        n_d    = n_eff;
        z_d    = 1'b1;
        zn_d   = 1'b0;
        tick_d = 1'b1;
      end else begin
        state_d = IDLE;
        z_d     = 1'b0;
        zn_d    = 1'b1;
        act_d   = 1'b0;
      end
    end else begin
      cnt_d = cnt_inc;
      z_d   = (cnt_inc < h);
      zn_d  = ~(cnt_inc < h);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= MIN_W;
      z_q     <= 1'b0;
      zn_q    <= 1'b1;
      tick_q  <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      z_q     <= z_d;
      zn_q    <= zn_d;
      tick_q  <= tick_d;
      act_q   <= act_d;
    end
  end

`ifdef GF180MCU_CLKDIV_DUTY50_EN
  logic zf_q;

  // Half-cycle extension of the high phase, only for odd ratios.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) zf_q <= 1'b0;
    else     zf_q <= z_q & n_q[0];
  end

  assign bus.Z  = z_q | zf_q;
  assign bus.ZN = zn_q & ~zf_q;
`else
  assign bus.Z  = z_q;
  assign bus.ZN = zn_q;
`endif

  assign bus.TICK = tick_q;
  assign bus.ACT  = act_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog.sv
// Bench for the programmable clock divider: ratio table plus hand-written corner sequences,
// checked cycle by cycle against a queue of expected outputs.
module tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog;

`ifdef GF180MCU_CLKDIV_DUTY50_EN
  localparam int D50 = 1;
`else
  localparam int D50 = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog_if #(.WIDTH(4)) bus ();

`ifdef USE_POWER_PINS
  wire vdd = 1'b1;
  wire vss = 1'b0;
`endif

  gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog #(.WIDTH(4), .MIN_DIV(2)) dut (
`ifdef USE_POWER_PINS
    .VDD(vdd),
    .VSS(vss),
`endif
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] div;
    int         hi;
    int         lo;
    int         periods;
  } vec_t;

  typedef struct {
    logic  z;
    logic  tick;
    logic  act;
    string tag;
  } exp_t;

  vec_t tbl[8];
  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got Z/ZN/TICK/ACT=%b want %b at %0t", name, got, want, $time);
    end
  endtask

  task automatic push(input logic z, input logic t, input logic a, input string tag);
    exp_t e;
    e.z = z; e.tick = t; e.act = a; e.tag = tag;
    sb.push_back(e);
  endtask

  // Advance one CLK and compare the DUT against the oldest expectation.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errs++;
      $display("FAIL scoreboard: no expectation queued at %0t", $time);
    end else begin
      e = sb.pop_front();
      chk(e.tag, {bus.Z, bus.ZN, bus.TICK, bus.ACT}, {e.z, ~e.z, e.tick, e.act});
    end
  endtask

  initial begin
    int hi_e;
    tbl[0] = '{div: 4'd4,  hi: 2, lo: 2, periods: 3};
    tbl[1] = '{div: 4'd0,  hi: 1, lo: 1, periods: 2};
    tbl[2] = '{div: 4'd1,  hi: 1, lo: 1, periods: 2};
    tbl[3] = '{div: 4'd5,  hi: 2, lo: 3, periods: 2};
    tbl[4] = '{div: 4'd15, hi: 7, lo: 8, periods: 1};
    tbl[5] = '{div: 4'd3,  hi: 1, lo: 2, periods: 2};
    tbl[6] = '{div: 4'd2,  hi: 1, lo: 1, periods: 2};
    tbl[7] = '{div: 4'd8,  hi: 4, lo: 4, periods: 1};

    bus.EN  = 1'b0;
    bus.DIV = 4'd4;

    // Reset state, then a long idle stretch with EN low.
    #12;
    chk("reset", {bus.Z, bus.ZN, bus.TICK, bus.ACT}, 4'b0100);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push(1'b0, 1'b0, 1'b0, "idle");
      cyc();
    end

    // Ratio table, run back-to-back; DIV is changed right before each period-end edge.
    for (int v = 0; v < 8; v++) begin
      bus.DIV = tbl[v].div;
      bus.EN  = 1'b1;
      // Sampled just after the rising edge, the half-cycle extension shows as one extra high sample.
      hi_e = tbl[v].hi + ((D50 != 0 && tbl[v].lo > tbl[v].hi) ? 1 : 0);
      for (int p = 0; p < tbl[v].periods; p++) begin
        for (int c = 0; c < tbl[v].hi + tbl[v].lo; c++) begin
          push(c < hi_e, c == 0, 1'b1, $sformatf("table div=%0d cyc=%0d", tbl[v].div, c));
          cyc();
        end
      end
    end
    bus.EN = 1'b0;
    push(1'b0, 1'b0, 1'b0, "park after table");
    cyc();

    // Ratio change mid-period: N=6 running, DIV=3 at cnt=2, then disable mid-period.
    bus.DIV = 4'd6;
    bus.EN  = 1'b1;
    push(1'b1, 1'b1, 1'b1, "chg n6 c0"); cyc();
    push(1'b1, 1'b0, 1'b1, "chg n6 c1"); cyc();
    push(1'b1, 1'b0, 1'b1, "chg n6 c2"); cyc();
    bus.DIV = 4'd3;
    push(1'b0, 1'b0, 1'b1, "chg n6 c3"); cyc();
    push(1'b0, 1'b0, 1'b1, "chg n6 c4"); cyc();
    push(1'b0, 1'b0, 1'b1, "chg n6 c5"); cyc();
    push(1'b1, 1'b1, 1'b1, "chg n3 c0"); cyc();
    push(D50 != 0, 1'b0, 1'b1, "chg n3 c1"); cyc();
    bus.EN = 1'b0;
    push(1'b0, 1'b0, 1'b1, "chg n3 c2"); cyc();
    push(1'b0, 1'b0, 1'b0, "chg idle"); cyc();

    // Disable at cnt=1 with a short EN pulse that misses the period end, then restart.
    bus.DIV = 4'd4;
    bus.EN  = 1'b1;
    push(1'b1, 1'b1, 1'b1, "dis c0"); cyc();
    push(1'b1, 1'b0, 1'b1, "dis c1"); cyc();
    bus.EN = 1'b0;
    push(1'b0, 1'b0, 1'b1, "dis c2"); cyc();
    bus.EN = 1'b1;
    push(1'b0, 1'b0, 1'b1, "dis c3 pulse"); cyc();
    bus.EN = 1'b0;
    push(1'b0, 1'b0, 1'b0, "dis idle0"); cyc();
    push(1'b0, 1'b0, 1'b0, "dis idle1"); cyc();
    bus.EN = 1'b1;
    push(1'b1, 1'b1, 1'b1, "restart c0"); cyc();
    push(1'b1, 1'b0, 1'b1, "restart c1"); cyc();

    // Asynchronous reset while Z is high.
    #2;
    rst = 1'b1;
    #1;
    chk("async reset", {bus.Z, bus.ZN, bus.TICK, bus.ACT}, 4'b0100);
    bus.EN = 1'b0;
    push(1'b0, 1'b0, 1'b0, "held in reset"); cyc();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 1'b0, 1'b0, "post-reset idle");
      cyc();
    end
    bus.DIV = 4'd2;
    bus.EN  = 1'b1;
    push(1'b1, 1'b1, 1'b1, "post-reset run c0"); cyc();
    bus.EN = 1'b0;
    push(1'b0, 1'b0, 1'b1, "post-reset run c1"); cyc();
    push(1'b0, 1'b0, 1'b0, "post-reset park"); cyc();

    checks++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL scoreboard drain: got %0d left want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
